// File: rtl/regfile_scoreboard.sv
// Register-file interlock: keeps a pending-write counter for every architectural
// register and stalls decode while a source operand (or a full rd counter) is in flight.
module regfile_scoreboard #(
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     id_valid_i,
   input  logic [ADDR_WIDTH-1:0]    id_rs1_addr_i,
   input  logic                     id_rs1_used_i,
   input  logic [ADDR_WIDTH-1:0]    id_rs2_addr_i,
   input  logic                     id_rs2_used_i,
   input  logic [ADDR_WIDTH-1:0]    id_rd_addr_i,
   input  logic                     id_rd_wren_i,
   input  logic                     wb_valid_i,
   input  logic [ADDR_WIDTH-1:0]    wb_rd_addr_i,
   input  logic                     kill_valid_i,
   input  logic [ADDR_WIDTH-1:0]    kill_rd_addr_i,
   output logic                     stall_o,
   output logic                     issue_o,
   output logic [2**ADDR_WIDTH-1:0] pending_o,
   output logic                     busy_o,
   output logic                     err_o
);

   localparam int NREG = 2**ADDR_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // Handshake: decode offers id_valid_i and holds it; the instruction moves on
   // (and its rd is booked) only in a cycle where issue_o = id_valid_i & ~stall_o.

   logic [CNT_WIDTH-1:0] cnt_q    [1:NREG-1];
   logic [CNT_WIDTH-1:0] cnt_d    [1:NREG-1];
   logic [CNT_WIDTH-1:0] cnt_view [NREG];
   logic                 err_q, err_d;
   logic                 raw1, raw2, waw_full;

   function automatic logic still_pending(input logic [CNT_WIDTH-1:0] c,
                                          input logic d_wb, input logic d_kill);
      logic [CNT_WIDTH:0] dec;
      dec = (CNT_WIDTH+1)'(d_wb) + (CNT_WIDTH+1)'(d_kill);
      return {1'b0, c} > dec;
   endfunction

   // x0 has no storage; it reads as an always-empty counter.
   always_comb begin
      cnt_view[0] = '0;
      for (int r = 1; r < NREG; r++) cnt_view[r] = cnt_q[r];
   end

   always_comb begin
      raw1 = id_rs1_used_i && (id_rs1_addr_i != '0) &&
             still_pending(cnt_view[id_rs1_addr_i],
                           wb_valid_i && (wb_rd_addr_i == id_rs1_addr_i),
                           kill_valid_i && (kill_rd_addr_i == id_rs1_addr_i));
      raw2 = id_rs2_used_i && (id_rs2_addr_i != '0) &&
             still_pending(cnt_view[id_rs2_addr_i],
                           wb_valid_i && (wb_rd_addr_i == id_rs2_addr_i),
                           kill_valid_i && (kill_rd_addr_i == id_rs2_addr_i));
      waw_full = id_rd_wren_i && (id_rd_addr_i != '0) &&
                 (cnt_view[id_rd_addr_i] == CNT_MAX) &&
                 !(wb_valid_i && (wb_rd_addr_i == id_rd_addr_i)) &&
                 !(kill_valid_i && (kill_rd_addr_i == id_rd_addr_i));
   end

   assign stall_o = id_valid_i & (raw1 | raw2 | waw_full);
   assign issue_o = id_valid_i & ~stall_o;

   // Net change per register is inc - dec_wb - dec_kill; clamp and flag either end.
   always_comb begin
      logic [CNT_WIDTH:0] sum;
      logic [CNT_WIDTH:0] dec;
      logic [CNT_WIDTH:0] diff;
      sum   = '0;
      dec   = '0;
      diff  = '0;
      err_d = err_q;
      for (int r = 1; r < NREG; r++) begin
         sum  = {1'b0, cnt_q[r]} +
                (CNT_WIDTH+1)'(issue_o && id_rd_wren_i && (id_rd_addr_i == ADDR_WIDTH'(r)));
         dec  = (CNT_WIDTH+1)'(wb_valid_i && (wb_rd_addr_i == ADDR_WIDTH'(r))) +
                (CNT_WIDTH+1)'(kill_valid_i && (kill_rd_addr_i == ADDR_WIDTH'(r)));
         diff = sum - dec;
         if (dec > sum) begin
            cnt_d[r] = '0;
            err_d    = 1'b1;
         end else if (diff[CNT_WIDTH]) begin
            cnt_d[r] = CNT_MAX;
            err_d    = 1'b1;
         end else begin
            cnt_d[r] = diff[CNT_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 1; r < NREG; r++) cnt_q[r] <= '0;
         err_q <= 1'b0;
      end else begin
         for (int r = 1; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         err_q <= err_d;
      end
   end

   always_comb begin
      pending_o[0] = 1'b0;
      for (int r = 1; r < NREG; r++) pending_o[r] = (cnt_q[r] != '0);
   end

   assign busy_o = |pending_o;
   assign err_o  = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a driver applies one vector per cycle and
// queues its hand-computed response; a monitor pops and compares before the next edge.
module tb_regfile_scoreboard;

   localparam int W = 36;  // {stall, issue, pending[31:0], busy, err}

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        id_valid_i = 1'b0;
   logic [4:0]  id_rs1_addr_i = '0;
   logic        id_rs1_used_i = 1'b0;
   logic [4:0]  id_rs2_addr_i = '0;
   logic        id_rs2_used_i = 1'b0;
   logic [4:0]  id_rd_addr_i = '0;
   logic        id_rd_wren_i = 1'b0;
   logic        wb_valid_i = 1'b0;
   logic [4:0]  wb_rd_addr_i = '0;
   logic        kill_valid_i = 1'b0;
   logic [4:0]  kill_rd_addr_i = '0;
   logic        stall_o, issue_o, busy_o, err_o;
   logic [31:0] pending_o;

   logic [W-1:0] exp_q[$];
   int           tag_q[$];
   logic         chk_strobe = 1'b0;
   int           n_vec = 0;
   int           n_miss = 0;
   int           vec_id = 0;

   regfile_scoreboard #(.ADDR_WIDTH(5), .CNT_WIDTH(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .id_valid_i(id_valid_i),
      .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_used_i(id_rs1_used_i),
      .id_rs2_addr_i(id_rs2_addr_i), .id_rs2_used_i(id_rs2_used_i),
      .id_rd_addr_i(id_rd_addr_i), .id_rd_wren_i(id_rd_wren_i),
      .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i),
      .kill_valid_i(kill_valid_i), .kill_rd_addr_i(kill_rd_addr_i),
      .stall_o(stall_o), .issue_o(issue_o), .pending_o(pending_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors still queued", exp_q.size());
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] pm(input int r);
      logic [31:0] m;
      m = '0;
      m[r] = 1'b1;
      return m;
   endfunction

   // driver: one vector per cycle, inputs change on the falling edge
   task automatic vec(input logic rst, input logic v,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic we,
                      input logic wbv, input logic [4:0] wbr,
                      input logic kv, input logic [4:0] kr,
                      input logic e_stall, input logic e_issue,
                      input logic [31:0] e_pend, input logic e_busy, input logic e_err);
      @(negedge clk_i);
      rst_ni = rst;
      id_valid_i = v;
      id_rs1_addr_i = rs1; id_rs1_used_i = u1;
      id_rs2_addr_i = rs2; id_rs2_used_i = u2;
      id_rd_addr_i = rd;   id_rd_wren_i = we;
      wb_valid_i = wbv;    wb_rd_addr_i = wbr;
      kill_valid_i = kv;   kill_rd_addr_i = kr;
      vec_id++;
      exp_q.push_back({e_stall, e_issue, e_pend, e_busy, e_err});
      tag_q.push_back(vec_id);
      chk_strobe = 1'b1;
   endtask

   // scoreboard monitor: samples 4 time units after the falling edge, 1 before the rising edge
   initial begin
      logic [W-1:0] exp_w, got_w;
      int tag;
      forever begin
         @(negedge clk_i);
         #4;
         if (chk_strobe) begin
            got_w = {stall_o, issue_o, pending_o, busy_o, err_o};
            n_vec++;
            if (exp_q.size() == 0) begin
               n_miss++;
               $display("FAIL sb_empty: got %h with no expected entry queued", got_w);
            end else begin
               exp_w = exp_q.pop_front();
               tag   = tag_q.pop_front();
               if (got_w !== exp_w) begin
                  n_miss++;
                  $display("FAIL vec%0d: got stall=%b issue=%b pend=%h busy=%b err=%b, need stall=%b issue=%b pend=%h busy=%b err=%b",
                           tag, got_w[35], got_w[34], got_w[33:2], got_w[1], got_w[0],
                           exp_w[35], exp_w[34], exp_w[33:2], exp_w[1], exp_w[0]);
               end
            end
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk_i);
      //   rst v  rs1 u1 rs2 u2 rd  we wbv wbr kv kr   stall issue pend        busy err
      // reset then idle; a reader of x5 goes straight through
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0, 0);
      vec(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0);
      // RAW on x3: issue, two stalled cycles, retire releases in the same cycle
      vec(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0);
      vec(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, pm(3),   1, 0);
      vec(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, pm(3),   1, 0);
      vec(1, 1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0,   0, 1, pm(3),   1, 0);
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0, 0);
      // x0: writes, reads, retires and kills are all ignored
      vec(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0);
      vec(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0);
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0,   0, 0, 32'h0,   0, 0);
      // WAW saturation on x7: three writes fill it, the fourth stalls until x7 retires
      vec(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0);
      vec(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   0, 1, pm(7),   1, 0);
      vec(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   0, 1, pm(7),   1, 0);
      vec(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   1, 0, pm(7),   1, 0);
      vec(1, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0,   0, 1, pm(7),   1, 0);
      // unused rs2=x7 does not stall; counter still 3, then drain 3 -> 2 -> 0
      vec(1, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0,   0, 1, pm(7),   1, 0);
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0,   0, 0, pm(7),   1, 0);
      vec(1, 1, 7, 1, 0, 0, 0, 0, 1, 7, 1, 7,   0, 1, pm(7),   1, 0);
      // x9: two writes; one retire alone still stalls a reader, retire+kill clears it
      vec(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0);
      vec(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   0, 1, pm(9),   1, 0);
      vec(1, 1, 9, 1, 0, 0, 0, 0, 1, 9, 0, 0,   1, 0, pm(9),   1, 0);
      vec(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   0, 1, pm(9),   1, 0);
      vec(1, 1, 9, 1, 9, 1, 0, 0, 1, 9, 1, 9,   0, 1, pm(9),   1, 0);
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0, 0);
      // underflow: retire x4 with nothing pending; err appears after the edge and sticks
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0,   0, 0, 32'h0,   0, 0);
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0, 1);
      vec(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 1);
      // issue rd=x5 while x5 retires: own source sees post-retire value, counter unchanged
      vec(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,   0, 1, 32'h0,   0, 1);
      vec(1, 1, 5, 1, 0, 0, 5, 1, 1, 5, 0, 0,   0, 1, pm(5),   1, 1);
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, pm(5),   1, 1);
      vec(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, pm(5),   1, 1);
      // asynchronous reset mid-operation clears everything at once, including err
      vec(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0);
      vec(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0);
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0, 0);

      @(negedge clk_i);
      chk_strobe = 1'b0;
      id_valid_i = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_i);
      #5;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL sb_drain: %0d expected entries left, need 0", exp_q.size());
      end

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
